wb_bfm_memory: RTL and testbench

- Wishbone B3 slave memory model. It is the responder counterpart that testbenches connect to the master BFM.
- Supports classic cycles, constant-address bursts and incrementing bursts (linear, wrap-4/8/16) using registered-feedback signalling, with byte-lane writes.
- Configurable per-beat wait states; out-of-range accesses terminate with err.
- Used as the target memory in bus-fabric and master-BFM regression benches.

---
 rtl/wb_bfm_memory_if.sv | 31 +++
 rtl/wb_bfm_memory.sv | 132 +++++++++++++
 tb/tb_wb_bfm_memory.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_bfm_memory_if.sv
// Wishbone B3 bus bundle between a master BFM and the memory model.
// Signal names follow the slave's view (_i into the slave, _o out of it).
interface wb_bfm_memory_if #(
  parameter int aw = 32,
  parameter int dw = 32
);
  logic [aw-1:0]   wb_adr_i;
  logic [dw-1:0]   wb_dat_i;
  logic [dw/8-1:0] wb_sel_i;
  logic            wb_we_i;
  logic            wb_cyc_i;
  logic            wb_stb_i;
  logic [2:0]      wb_cti_i;
  logic [1:0]      wb_bte_i;
  logic [dw-1:0]   wb_dat_o;
  logic            wb_ack_o;
  logic            wb_err_o;
  logic            wb_rty_o;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i,
    input  wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i,
    output wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );
endinterface

// File: rtl/wb_bfm_memory.sv
// Wishbone B3 slave memory: classic and registered-feedback bursts,
// byte-lane writes, fixed wait states, err on out-of-range words.
module wb_bfm_memory #(
  parameter int            aw          = 32,
  parameter int            dw          = 32,
  parameter int            MEM_WORDS   = 256,
  parameter logic [aw-1:0] BASE_ADR    = '0,
  parameter int            WAIT_STATES = 0
) (
  input logic            wb_clk_i,
  input logic            wb_rst_i,
  wb_bfm_memory_if.slave wb
);
  localparam int ADR_LSB = $clog2(dw/8);
  localparam int SW      = dw/8;
  localparam int MIW     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [aw-1:0] idx_q, idx_d;
  logic [1:0]    bte_q, bte_d;
  logic [3:0]    cnt_q, cnt_d;

  logic [dw-1:0] mem [MEM_WORDS];

  logic          req;
  logic          in_rng;
  logic          resp;
  logic          burst;
  logic          wr_en;
  logic [aw-1:0] req_idx;
  logic [aw-1:0] inc_idx;
  logic [aw-1:0] wmask;
  logic [dw-1:0] rd_word;

  assign req     = wb.wb_cyc_i & wb.wb_stb_i;
  assign req_idx = (wb.wb_adr_i - BASE_ADR) >> ADR_LSB;
  assign in_rng  = idx_q < aw'(MEM_WORDS);
  assign resp    = state_q == S_RESP;
  assign burst   = (wb.wb_cti_i == 3'b001) ||
                   (wb.wb_cti_i == 3'b010);
  assign wr_en   = resp & in_rng & req & wb.wb_we_i;
  assign rd_word = mem[idx_q[MIW-1:0]];

  assign wb.wb_ack_o = resp & in_rng;
  assign wb.wb_err_o = resp & ~in_rng;
  assign wb.wb_rty_o = 1'b0;
  assign wb.wb_dat_o = (wb.wb_ack_o & ~wb.wb_we_i) ?
                       rd_word : '0;

  // Wrap mask: only the low bits advance, upper bits hold.
  always_comb begin
    wmask = '1;
    unique case (bte_q)
      2'b01:   wmask = aw'(3);
      2'b10:   wmask = aw'(7);
      2'b11:   wmask = aw'(15);
      default: wmask = '1;
    endcase
  end

  assign inc_idx = (idx_q & ~wmask) |
                   ((idx_q + aw'(1)) & wmask);

  // Beat sequencing: accept, wait, respond, then gap or next beat.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    bte_d   = bte_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          idx_d   = req_idx;
          bte_d   = wb.wb_bte_i;
          cnt_d   = WS;
          state_d = (WS == 4'd0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (!req) begin
          state_d = S_IDLE;
        end else if (!in_rng || !burst) begin
          state_d = S_GAP;
        end else begin
          if (wb.wb_cti_i == 3'b010) idx_d = inc_idx;
          cnt_d   = WS;
          state_d = (WS == 4'd0) ? S_RESP : S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state; reset drops ack/err at once.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      bte_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      bte_q   <= bte_d;
      cnt_q   <= cnt_d;
    end
  end

  // Byte-lane write at the edge closing an acked write beat.
  always_ff @(posedge wb_clk_i) begin
    if (wr_en) begin
      for (int i = 0; i < SW; i++) begin
        if (wb.wb_sel_i[i])
          mem[idx_q[MIW-1:0]][i*8 +: 8] <= wb.wb_dat_i[i*8 +: 8];
      end
    end
  end
endmodule

// File: tb/tb_wb_bfm_memory.sv
// Directed bench for wb_bfm_memory: one instance with no wait states,
// one with three, sharing a single master drive.
module tb_wb_bfm_memory;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        use3  = 1'b0;
  logic        cyc_r = 1'b0;
  logic        stb_r = 1'b0;
  logic        we_r  = 1'b0;
  logic [31:0] adr_r = '0;
  logic [31:0] dat_r = '0;
  logic [3:0]  sel_r = '0;
  logic [2:0]  cti_r = '0;
  logic [1:0]  bte_r = '0;

  int n_chk  = 0;
  int n_fail = 0;

  wb_bfm_memory_if #(.aw(32), .dw(32)) if0 ();
  wb_bfm_memory_if #(.aw(32), .dw(32)) if3 ();

  assign if0.wb_adr_i = adr_r;
  assign if0.wb_dat_i = dat_r;
  assign if0.wb_sel_i = sel_r;
  assign if0.wb_we_i  = we_r;
  assign if0.wb_cyc_i = cyc_r & ~use3;
  assign if0.wb_stb_i = stb_r & ~use3;
  assign if0.wb_cti_i = cti_r;
  assign if0.wb_bte_i = bte_r;

  assign if3.wb_adr_i = adr_r;
  assign if3.wb_dat_i = dat_r;
  assign if3.wb_sel_i = sel_r;
  assign if3.wb_we_i  = we_r;
  assign if3.wb_cyc_i = cyc_r & use3;
  assign if3.wb_stb_i = stb_r & use3;
  assign if3.wb_cti_i = cti_r;
  assign if3.wb_bte_i = bte_r;

  wb_bfm_memory #(
    .aw(32), .dw(32), .MEM_WORDS(256),
    .BASE_ADR(32'h0), .WAIT_STATES(0)
  ) dut0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb(if0)
  );

  wb_bfm_memory #(
    .aw(32), .dw(32), .MEM_WORDS(256),
    .BASE_ADR(32'h0), .WAIT_STATES(3)
  ) dut3 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb(if3)
  );

  logic        ack, err;
  logic [31:0] rdat;
  assign ack  = use3 ? if3.wb_ack_o : if0.wb_ack_o;
  assign err  = use3 ? if3.wb_err_o : if0.wb_err_o;
  assign rdat = use3 ? if3.wb_dat_o : if0.wb_dat_o;

  typedef struct {
    bit          u3;
    bit          we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    bit          eack;
    bit          eerr;
    logic [31:0] edat;
  } vec_t;

  vec_t tv[14];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit u3, input bit we,
                       input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic [2:0] cti,
                       input logic [1:0] bte);
    @(posedge clk); #1;
    use3  = u3;
    we_r  = we;
    adr_r = adr;
    dat_r = dat;
    sel_r = sel;
    cti_r = cti;
    bte_r = bte;
    cyc_r = 1'b1;
    stb_r = 1'b1;
  endtask

  task automatic wait_resp(output logic a, output logic e,
                           output logic [31:0] d, output int lat);
    a = 1'b0; e = 1'b0; d = '0; lat = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ack || err) begin
        a = ack; e = err; d = rdat;
        return;
      end
      lat++;
    end
    lat = -1;
  endtask

  task automatic classic(input string nm, input vec_t v);
    logic a, e;
    logic [31:0] d;
    int lat;
    drive(v.u3, v.we, v.adr, v.dat, v.sel, 3'b000, 2'b00);
    wait_resp(a, e, d, lat);
    chk({nm, " ack"}, 32'(a), 32'(v.eack));
    chk({nm, " err"}, 32'(e), 32'(v.eerr));
    chk({nm, " dat"}, d, v.edat);
    chk({nm, " lat"}, 32'(lat), v.u3 ? 32'd4 : 32'd1);
    @(posedge clk); #1;
    cyc_r = 1'b0;
    stb_r = 1'b0;
    @(negedge clk);
    chk({nm, " gap"}, 32'(ack | err), 32'd0);
  endtask

  task automatic burst(input string nm, input bit u3, input bit we,
                       input logic [31:0] adr, input logic [2:0] cti,
                       input logic [1:0] bte, input int n,
                       input logic [31:0] d [4]);
    logic a, e;
    logic [31:0] rd;
    int lat;
    int ws;
    ws = u3 ? 3 : 0;
    drive(u3, we, adr, we ? d[0] : 32'h0, 4'hF,
          (n == 1) ? 3'b111 : cti, bte);
    for (int b = 0; b < n; b++) begin
      wait_resp(a, e, rd, lat);
      chk($sformatf("%s b%0d ack", nm, b), 32'(a), 32'd1);
      chk($sformatf("%s b%0d lat", nm, b), 32'(lat),
          32'((b == 0) ? ws + 1 : ws));
      if (!we)
        chk($sformatf("%s b%0d dat", nm, b), rd, d[b]);
      @(posedge clk); #1;
      if (b < n - 1) begin
        adr_r = 32'hFFFF_FFF0;
        dat_r = we ? d[b+1] : 32'h0;
        if (b + 1 == n - 1) cti_r = 3'b111;
      end else begin
        cyc_r = 1'b0;
        stb_r = 1'b0;
        cti_r = 3'b000;
      end
    end
    @(negedge clk);
    chk({nm, " gap"}, 32'(ack | err), 32'd0);
  endtask

  initial begin
    logic [31:0] bd [4];
    logic a, e;
    logic [31:0] d;
    int lat;
    int seen;

    tv[0]  = '{0, 1, 32'h10,  32'hDEADBEEF, 4'hF, 1, 0, 32'h0};
    tv[1]  = '{0, 0, 32'h10,  32'h0,        4'hF, 1, 0, 32'hDEADBEEF};
    tv[2]  = '{0, 1, 32'h10,  32'h11223344, 4'h5, 1, 0, 32'h0};
    tv[3]  = '{0, 0, 32'h10,  32'h0,        4'hF, 1, 0, 32'hDE22BE44};
    tv[4]  = '{0, 1, 32'h0,   32'h0BADF00D, 4'hF, 1, 0, 32'h0};
    tv[5]  = '{0, 1, 32'h400, 32'h55555555, 4'hF, 0, 1, 32'h0};
    tv[6]  = '{0, 0, 32'h400, 32'h0,        4'hF, 0, 1, 32'h0};
    tv[7]  = '{0, 0, 32'h0,   32'h0,        4'hF, 1, 0, 32'h0BADF00D};
    tv[8]  = '{0, 1, 32'h3FC, 32'hA5A5A5A5, 4'hF, 1, 0, 32'h0};
    tv[9]  = '{0, 0, 32'h3FC, 32'h0,        4'hF, 1, 0, 32'hA5A5A5A5};
    tv[10] = '{0, 1, 32'h30,  32'h12345678, 4'hF, 1, 0, 32'h0};
    tv[11] = '{1, 1, 32'h20,  32'hCAFEF00D, 4'hF, 1, 0, 32'h0};
    tv[12] = '{1, 0, 32'h20,  32'h0,        4'hF, 1, 0, 32'hCAFEF00D};
    tv[13] = '{1, 1, 32'h30,  32'h11111111, 4'hF, 1, 0, 32'h0};

    @(negedge clk);
    @(negedge clk);
    chk("rst ack0", 32'(if0.wb_ack_o), 32'd0);
    chk("rst err0", 32'(if0.wb_err_o), 32'd0);
    chk("rst rty0", 32'(if0.wb_rty_o), 32'd0);
    chk("rst dat0", if0.wb_dat_o, 32'h0);
    chk("rst ack3", 32'(if3.wb_ack_o), 32'd0);
    chk("rst dat3", if3.wb_dat_o, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++)
      classic($sformatf("vec%0d", i), tv[i]);

    bd = '{32'd0, 32'd1, 32'd2, 32'd3};
    burst("wrap4 wr", 0, 1, 32'h18, 3'b010, 2'b01, 4, bd);
    bd = '{32'd2, 32'd3, 32'd0, 32'd1};
    burst("lin rd", 0, 0, 32'h10, 3'b010, 2'b00, 4, bd);
    bd = '{32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 32'h0};
    burst("const rd", 1, 0, 32'h20, 3'b001, 2'b00, 3, bd);

    drive(0, 1, 32'h30, 32'h99999999, 4'hF, 3'b000, 2'b00);
    wait_resp(a, e, d, lat);
    chk("rstresp ack before", 32'(a), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstresp ack", 32'(ack), 32'd0);
    chk("rstresp err", 32'(err), 32'd0);
    @(posedge clk); #1;
    cyc_r = 1'b0;
    stb_r = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    classic("rstresp rd", '{0, 0, 32'h30, 32'h0, 4'hF, 1, 0, 32'h12345678});

    drive(1, 1, 32'h30, 32'h99999999, 4'hF, 3'b000, 2'b00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstwait ack", 32'(ack | err), 32'd0);
    @(negedge clk);
    cyc_r = 1'b0;
    stb_r = 1'b0;
    rst   = 1'b0;
    classic("rstwait rd", '{1, 0, 32'h30, 32'h0, 4'hF, 1, 0, 32'h11111111});

    drive(1, 1, 32'h30, 32'h77777777, 4'hF, 3'b000, 2'b00);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1;
    cyc_r = 1'b0;
    stb_r = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ack || err) seen++;
    end
    chk("abort ack", 32'(seen), 32'd0);
    classic("abort rd", '{1, 0, 32'h30, 32'h0, 4'hF, 1, 0, 32'h11111111});

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
